// File: rtl/gcd_driver.sv
// Initiator-side sequencer for the binary-GCD core: buffers operand pairs,
// launches them on the core, retires each result downstream in push order.
module gcd_driver #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             In_valid,
  output logic             In_ready,
  input  logic [WIDTH-1:0] In_A,
  input  logic [WIDTH-1:0] In_B,
  output logic             Start,
  output logic             Ack,
  output logic             Core_rst,
  output logic [WIDTH-1:0] Ain,
  output logic [WIDTH-1:0] Bin,
  input  logic             q_I,
  input  logic             q_Done,
  input  logic [WIDTH-1:0] AB_GCD,
  output logic             Res_valid,
  input  logic             Res_ready,
  output logic [WIDTH-1:0] Res_gcd,
  output logic             Res_err,
  output logic             Busy,
  output logic [7:0]       Err_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, LAUNCH, WAIT, ACK, RECOVER, OUT
  } state_t;

  state_t state, next_state;

  logic [WIDTH-1:0] fifo_a [DEPTH];
  logic [WIDTH-1:0] fifo_b [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [TMR_W-1:0] timer;

  logic             push, pop, zero_op;
  logic [WIDTH-1:0] head_a, head_b;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign head_a    = fifo_a[rd_ptr];
  assign head_b    = fifo_b[rd_ptr];
  assign zero_op   = (head_a == '0) || (head_b == '0);
  assign In_ready  = (count < CNT_W'(DEPTH));
  assign push      = In_valid && In_ready;
  assign pop       = (state == IDLE) && (count != '0) && q_I;
  assign Busy      = (state != IDLE);
  assign Res_valid = (state == OUT);

  // Operand storage carries no reset; only pointers and count define contents.
  always_ff @(posedge Clk) begin
    if (push) begin
      fifo_a[wr_ptr] <= In_A;
      fifo_b[wr_ptr] <= In_B;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (pop) next_state = zero_op ? OUT : LAUNCH;
      LAUNCH:  next_state = WAIT;
      WAIT: begin
        if (q_Done)                 next_state = ACK;
        else if (timer == TMR_LAST) next_state = RECOVER;
      end
      ACK:     next_state = OUT;
      RECOVER: next_state = OUT;
      OUT:     if (Res_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Core strobes are registered from next_state so each is high exactly
  // during the cycle its state is occupied.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      Start    <= 1'b0;
      Ack      <= 1'b0;
      Core_rst <= 1'b0;
      Ain      <= '0;
      Bin      <= '0;
      Res_gcd  <= '0;
      Res_err  <= 1'b0;
      Err_cnt  <= '0;
      timer    <= '0;
    end else begin
      state    <= next_state;
      Start    <= (next_state == LAUNCH);
      Ack      <= (next_state == ACK);
      Core_rst <= (next_state == RECOVER);

      if (pop) begin
        Ain <= head_a;
        Bin <= head_b;
        if (zero_op) begin
          Res_gcd <= '0;
          Res_err <= 1'b1;
        end
      end

      if (state == LAUNCH) timer <= '0;
      else if (state == WAIT) timer <= timer + 1'b1;

      if (state == WAIT) begin
        if (q_Done) begin
          Res_gcd <= AB_GCD;
          Res_err <= 1'b0;
        end else if (timer == TMR_LAST) begin
          Res_gcd <= '0;
          Res_err <= 1'b1;
        end
      end

      if ((state == OUT) && Res_ready && Res_err) Err_cnt <= sat_inc(Err_cnt);
    end
  end

endmodule

// File: tb/tb_gcd_driver.sv
// Directed bench for gcd_driver with a behavioural GCD core that can be
// told to hang so the timeout recovery path is exercised.
module tb_gcd_driver;

  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         Reset_n;
  logic         In_valid;
  logic         In_ready;
  logic [W-1:0] In_A, In_B;
  logic         Start, Ack, Core_rst;
  logic [W-1:0] Ain, Bin;
  logic         q_I, q_Done;
  logic [W-1:0] AB_GCD;
  logic         Res_valid, Res_ready;
  logic [W-1:0] Res_gcd;
  logic         Res_err, Busy;
  logic [7:0]   Err_cnt;

  gcd_driver #(.WIDTH(W), .DEPTH(4), .TIMEOUT(15)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .In_valid(In_valid), .In_ready(In_ready),
    .In_A(In_A), .In_B(In_B), .Start(Start), .Ack(Ack), .Core_rst(Core_rst),
    .Ain(Ain), .Bin(Bin), .q_I(q_I), .q_Done(q_Done), .AB_GCD(AB_GCD),
    .Res_valid(Res_valid), .Res_ready(Res_ready), .Res_gcd(Res_gcd),
    .Res_err(Res_err), .Busy(Busy), .Err_cnt(Err_cnt)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_fail = 0;

  // Behavioural core: idle -> compute (fixed latency) -> done until Ack.
  logic [1:0] cs;
  int         ccnt;
  logic [W-1:0] ca, cb, cres;
  logic       hang, core_reset;

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    int x, y, t;
    x = a; y = b;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return W'(x);
  endfunction

  always @(posedge Clk) begin
    if (core_reset || Core_rst) cs <= 2'd0;
    else case (cs)
      2'd0: if (Start) begin ca <= Ain; cb <= Bin; ccnt <= 5; cs <= 2'd1; end
      2'd1: if (!hang) begin
        if (ccnt == 0) begin cs <= 2'd2; cres <= ref_gcd(ca, cb); end
        else ccnt <= ccnt - 1;
      end
      2'd2: if (Ack) cs <= 2'd0;
      default: cs <= 2'd0;
    endcase
  end

  assign q_I    = (cs == 2'd0);
  assign q_Done = (cs == 2'd2);
  assign AB_GCD = cres;

  int cyc = 0, n_start = 0, n_ack = 0, n_rst = 0, start_cyc = 0, rst_cyc = 0, excl_bad = 0;
  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (Start)    begin n_start <= n_start + 1; start_cyc <= cyc; end
    if (Ack)      n_ack <= n_ack + 1;
    if (Core_rst) begin n_rst <= n_rst + 1; rst_cyc <= cyc; end
  end
  always @(negedge Clk)
    if (int'(Start) + int'(Ack) + int'(Core_rst) > 1) excl_bad <= excl_bad + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the push edge.
  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    int w = 0;
    while (!In_ready && w < 300) begin @(negedge Clk); w++; end
    if (!In_ready) chk("push_ready_wait", 32'(In_ready), 1);
    else begin
      In_valid = 1'b1; In_A = a; In_B = b;
      @(negedge Clk);
      In_valid = 1'b0;
    end
  endtask

  task automatic get_result(input string name, input logic [W-1:0] g, input logic e);
    int w = 0;
    while (!Res_valid && w < 300) begin @(negedge Clk); w++; end
    chk({name, "_valid"}, 32'(Res_valid), 1);
    if (Res_valid) begin
      chk({name, "_gcd"}, 32'(Res_gcd), 32'(g));
      chk({name, "_err"}, 32'(Res_err), 32'(e));
      Res_ready = 1'b1;
      @(negedge Clk);
      Res_ready = 1'b0;
    end
  endtask

  typedef struct {
    logic [W-1:0] a, b, g;
    logic         e;
  } vec_t;
  vec_t tv [7];

  initial begin
    int s0, stab_bad;
    logic [W-1:0] g0;
    logic e0;

    tv[0] = '{8'd17,  8'd5,   8'd1,  1'b0};
    tv[1] = '{8'd48,  8'd18,  8'd6,  1'b0};
    tv[2] = '{8'd8,   8'd8,   8'd8,  1'b0};
    tv[3] = '{8'd128, 8'd32,  8'd32, 1'b0};
    tv[4] = '{8'd255, 8'd0,   8'd0,  1'b1};
    tv[5] = '{8'd1,   8'd200, 8'd1,  1'b0};
    tv[6] = '{8'd255, 8'd85,  8'd85, 1'b0};

    Reset_n = 1'b0; core_reset = 1'b1; hang = 1'b0;
    In_valid = 1'b0; In_A = '0; In_B = '0; Res_ready = 1'b0;
    #1;
    chk("rst_start", 32'(Start), 0);
    chk("rst_ack", 32'(Ack), 0);
    chk("rst_core_rst", 32'(Core_rst), 0);
    chk("rst_ain", 32'(Ain), 0);
    chk("rst_res_valid", 32'(Res_valid), 0);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_err_cnt", 32'(Err_cnt), 0);
    chk("rst_in_ready", 32'(In_ready), 1);
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1; core_reset = 1'b0;
    @(negedge Clk);

    push(8'd36, 8'd24);
    get_result("basic", 8'd12, 1'b0);
    chk("basic_starts", 32'(n_start), 1);
    chk("basic_acks", 32'(n_ack), 1);

    s0 = n_start;
    push(8'd0, 8'd9);
    get_result("zero_op", 8'd0, 1'b1);
    chk("zero_op_no_start", 32'(n_start - s0), 0);
    chk("zero_op_err_cnt", 32'(Err_cnt), 1);

    fork
      for (int i = 0; i < 7; i++) push(tv[i].a, tv[i].b);
      for (int j = 0; j < 7; j++) get_result($sformatf("tbl%0d", j), tv[j].g, tv[j].e);
    join
    chk("tbl_err_cnt", 32'(Err_cnt), 2);

    push(8'd36, 8'd24);
    begin
      int w = 0;
      while (!Res_valid && w < 300) begin @(negedge Clk); w++; end
    end
    s0 = n_start; g0 = Res_gcd; e0 = Res_err; stab_bad = 0;
    fork
      begin
        push(8'd20, 8'd15); push(8'd100, 8'd75); push(8'd7, 8'd3); push(8'd81, 8'd27);
      end
      for (int k = 0; k < 10; k++) begin
        if (!Res_valid || Res_gcd !== g0 || Res_err !== e0) stab_bad++;
        @(negedge Clk);
      end
    join
    chk("stall_stable", 32'(stab_bad), 0);
    chk("stall_no_start", 32'(n_start - s0), 0);
    chk("stall_fifo_full", 32'(In_ready), 0);
    get_result("stall0", 8'd12, 1'b0);
    get_result("stall1", 8'd5, 1'b0);
    get_result("stall2", 8'd25, 1'b0);
    get_result("stall3", 8'd1, 1'b0);
    get_result("stall4", 8'd27, 1'b0);

    hang = 1'b1;
    s0 = n_rst;
    push(8'd10, 8'd4);
    get_result("timeout", 8'd0, 1'b1);
    chk("timeout_core_rst_once", 32'(n_rst - s0), 1);
    chk("timeout_delay", 32'(rst_cyc - start_cyc), 16);
    chk("timeout_err_cnt", 32'(Err_cnt), 3);
    hang = 1'b0;

    s0 = n_start;
    push(8'd36, 8'd24);
    push(8'd5, 8'd5);
    begin
      int w = 0;
      while (n_start == s0 && w < 100) begin @(negedge Clk); w++; end
    end
    chk("mid_reset_started", 32'(n_start - s0), 1);
    repeat (2) @(negedge Clk);
    chk("mid_reset_busy_before", 32'(Busy), 1);
    #2 Reset_n = 1'b0; core_reset = 1'b1;
    #1;
    chk("mid_reset_busy", 32'(Busy), 0);
    chk("mid_reset_valid", 32'(Res_valid), 0);
    chk("mid_reset_start", 32'(Start), 0);
    chk("mid_reset_ain", 32'(Ain), 0);
    chk("mid_reset_bin", 32'(Bin), 0);
    chk("mid_reset_gcd", 32'(Res_gcd), 0);
    chk("mid_reset_err_cnt", 32'(Err_cnt), 0);
    chk("mid_reset_in_ready", 32'(In_ready), 1);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    core_reset = 1'b0;
    push(8'd36, 8'd24);
    get_result("post_reset", 8'd12, 1'b0);
    repeat (30) @(negedge Clk);
    chk("post_reset_fifo_empty", 32'(Res_valid), 0);
    chk("post_reset_idle", 32'(Busy), 0);
    chk("strobe_exclusive", 32'(excl_bad), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gcd_driver.md
# gcd_driver

Initiator-side sequencer for the binary-GCD core. It accepts operand pairs from an upstream FIFO interface and launches each pair on the core with the Start handshake. It waits for q_Done, captures the result, and retires the core with Ack. Results go downstream through a valid/ready port in push order. It sits between the host/test logic and the GCD core, and recovers from a hung core by timeout.

## Interface
Parameters:
- WIDTH, 8, operand/result width; matches core Ain/Bin/AB_GCD.
- DEPTH, 4, operand FIFO entries (power of 2, ≥2).
- TIMEOUT, 1023, max cycles in WAIT before recovery (≥2).

Ports:
- Clk  in  1  single clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- In_valid  in  1  operand pair offered.
- In_ready  out  1  FIFO not full (count < DEPTH).
- In_A, In_B  in  WIDTH  operand pair.
- Start  out  1  to core Start.
- Ack  out  1  to core Ack.
- Core_rst  out  1  to core Reset (active-high), one-cycle pulse on timeout.
- Ain, Bin  out  WIDTH  to core operands, registered.
- q_I, q_Done  in  1  core state flags.
- AB_GCD  in  WIDTH  core result.
- Res_valid  out  1  result available.
- Res_ready  in  1  downstream accepts.
- Res_gcd  out  WIDTH  GCD, 0 when Res_err.
- Res_err  out  1  zero operand or timeout.
- Busy  out  1  state ≠ IDLE.
- Err_cnt  out  8  saturating count of errored results.

## Operation
- FIFO: push on In_valid && In_ready. Pop happens only in IDLE. Push and pop in the same cycle is legal; count unchanged. Pointers wrap modulo DEPTH.
- FSM states: IDLE, LAUNCH, WAIT, ACK, RECOVER, OUT.
- IDLE: if FIFO non-empty and q_I=1, pop the head into Ain/Bin.
  - If either operand is 0: Res_gcd←0, Res_err←1 → OUT. The core is never started.
  - Otherwise → LAUNCH.
  - If q_I=0, the driver stays in IDLE without popping.
- LAUNCH: Start=1 for exactly one cycle; timer←0 → WAIT.
- WAIT: timer increments each cycle.
  - q_Done=1: Res_gcd←AB_GCD, Res_err←0 → ACK.
  - Else if timer==TIMEOUT-1 → RECOVER.
  - q_Done takes priority when both conditions hold in the same cycle.
- ACK: Ack=1 for exactly one cycle → OUT.
- RECOVER: Core_rst=1 for one cycle; Res_gcd←0, Res_err←1 → OUT.
- OUT: Res_valid=1 with Res_gcd/Res_err stable. On Res_ready → IDLE. Err_cnt increments (saturating at 255) on the accepting cycle when Res_err=1.
- Ain/Bin hold their value from pop until the next pop.
- Start, Ack and Core_rst are mutually exclusive and never asserted outside their states.
- Reset mid-operation: all state clears immediately and FIFO contents are discarded. The core is not reset by the driver in this case; the next launch waits for q_I.

## Timing
- Reset values: Start=0, Ack=0, Core_rst=0, Ain=Bin=0, Res_valid=0, Res_gcd=0, Res_err=0, Busy=0, Err_cnt=0. FIFO is empty, so In_ready=1.
- All outputs are registered except In_ready, Busy and Res_valid, which decode from registered state/count.
- Push to Start: minimum 2 cycles. The push edge makes the FIFO non-empty, the IDLE pop edge loads Ain/Bin, and Start is high during the following cycle.
- Ain/Bin are stable the whole cycle Start=1, so the core samples them together with Start.
- q_Done to Res_valid: 2 cycles (the WAIT capture edge, then the ACK edge).
- Minimum turnaround per pair with Res_ready held high: LAUNCH + ≥1 WAIT + ACK + OUT + IDLE = 5 cycles plus core compute time.
- Zero-operand pair: pop edge to Res_valid in 1 cycle.
- Timeout: Core_rst is high TIMEOUT+1 cycles after the Start cycle. Res_valid follows 1 cycle later.

## Test plan
- Push (36,24) with the behavioural core attached → Start pulses once, Ack pulses once, Res_gcd=12, Res_err=0.
- Push (17,5),(48,18),(8,8),(128,32) back-to-back → results arrive in order as 1, 6, 8, 32. In_ready drops after the 4th push if no pop has occurred yet.
- Push (0,9) → no Start, Res_gcd=0, Res_err=1, Err_cnt=1.
- Core stub that never asserts q_Done, TIMEOUT=15 → Core_rst pulses 16 cycles after Start, then Res_err=1, Res_gcd=0.
- Hold Res_ready=0 for 10 cycles after Res_valid → Res_gcd/Res_err stay stable and no new Start is issued. FIFO keeps accepting until full.
- Drop Reset_n during WAIT → all outputs return to reset values asynchronously and FIFO is empty. A fresh (36,24) push after reset release yields 12.
